// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: runs one SPI character per start_i, timed by the clock-enable generator's clken ticks.
// Define SPI_XFER_AUTO_SS_EN to drive the slave selects from the transfer FSM instead of ss_sel_i directly.
//   state  | meaning
//   IDLE   | sclk follows cpol_i, generator off, waiting for start_i
//   ACTIVE | 2N sclk edges: shift mosi, sample miso
//   HOLD   | one extra tick of slave-select hold
//   DONE   | one-cycle done pulse, rx_data_o updated
module spi_xfer_ctrl #(
  parameter int MAX_CHAR = 32,
  parameter int SS_W     = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [$clog2(MAX_CHAR):0]   char_len_i,
  input  logic                        cpol_i,
  input  logic                        cpha_i,
  input  logic                        lsb_i,
  input  logic [MAX_CHAR-1:0]         tx_data_i,
  input  logic [SS_W-1:0]             ss_sel_i,
  output logic                        clkgen_en_o,
  input  logic                        clken_i,
  output logic                        sclk_o,
  output logic                        mosi_o,
  input  logic                        miso_i,
  output logic [SS_W-1:0]             ss_no,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [MAX_CHAR-1:0]         rx_data_o
);
  localparam int LEN_W = $clog2(MAX_CHAR) + 1;
  localparam int IDX_W = $clog2(MAX_CHAR);
  localparam int CNT_W = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, DONE} state_t;
  state_t state_q, state_d;

  logic [LEN_W-1:0]    n_q, n_start, next_bit;
  logic                cpha_q, lsb_q;
  logic [MAX_CHAR-1:0] tx_q, rx_sr;
  logic [CNT_W-1:0]    cnt_q;
  logic                sclk_q, mosi_q;
  logic                last_edge, shift_evt, sample_evt;
  logic [IDX_W-1:0]    tx_idx, start_idx;

  always_comb begin
    n_start = char_len_i;
    if (char_len_i == '0 || char_len_i > LEN_W'(MAX_CHAR)) n_start = LEN_W'(MAX_CHAR);
  end

  assign start_idx  = lsb_i ? '0 : IDX_W'(n_start - LEN_W'(1));
  assign last_edge  = (cnt_q == {n_q, 1'b0} - CNT_W'(1));
  // Bit presented by a shift edge: (count+1)/2 covers both trailing (cpha=0) and leading (cpha=1) edges.
  assign next_bit   = LEN_W'((cnt_q + CNT_W'(1)) >> 1);
  assign tx_idx     = lsb_q ? IDX_W'(next_bit) : IDX_W'(n_q - LEN_W'(1) - next_bit);
  assign shift_evt  = cpha_q ? ~cnt_q[0] : (cnt_q[0] & ~last_edge);
  assign sample_evt = cpha_q ? cnt_q[0] : ~cnt_q[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    clkgen_en_o = 1'b0;
    case (state_q)
      IDLE: if (start_i) state_d = ACTIVE;
      ACTIVE: begin
        busy_o      = 1'b1;
        clkgen_en_o = 1'b1;
        if (clken_i && last_edge) state_d = HOLD;
      end
      HOLD: begin
        busy_o      = 1'b1;
        clkgen_en_o = 1'b1;
        if (clken_i) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_q       <= '0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      tx_q      <= '0;
      rx_sr     <= '0;
      cnt_q     <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      rx_data_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          sclk_q <= cpol_i;
          if (start_i) begin
            n_q    <= n_start;
            cpha_q <= cpha_i;
            lsb_q  <= lsb_i;
            tx_q   <= tx_data_i;
            rx_sr  <= '0;
            cnt_q  <= '0;
            mosi_q <= tx_data_i[start_idx];
          end
        end
        ACTIVE: if (clken_i) begin
          sclk_q <= ~sclk_q;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (shift_evt) mosi_q <= tx_q[tx_idx];
          // Only N samples land, so bits at and above N stay at their cleared value.
          if (sample_evt) begin
            if (lsb_q) rx_sr <= (rx_sr >> 1) | (MAX_CHAR'(miso_i) << (n_q - LEN_W'(1)));
            else       rx_sr <= {rx_sr[MAX_CHAR-2:0], miso_i};
          end
        end
        HOLD: if (clken_i) rx_data_o <= rx_sr;
        default: ;
      endcase
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

`ifdef SPI_XFER_AUTO_SS_EN
  logic [SS_W-1:0] ss_lat;

  always_ff @(posedge clk_i) begin
    if (rst_i)                          ss_lat <= '0;
    else if (state_q == IDLE && start_i) ss_lat <= ss_sel_i;
  end

  assign ss_no = (state_q == IDLE) ? '1 : ~ss_lat;
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) ss_no <= '1;
    else       ss_no <= ~ss_sel_i;
  end
`endif

endmodule
